// File: rtl/neuron_stage_pkg.sv
// -----------------------------------------------------------------------------
// neuron_stage_pkg
//   Shared network package for the layer pipeline.
//   - accumWidth(): per-channel accumulator width, clog2(NP)+WF.
//   - stateWidth(): per-channel state width (full accumulator width for
//     hidden layers, WF for the output layer).
//   - HIDDEN_YES / HIDDEN_NO: layer-kind strings used by the HIDDEN parameter.
//   - mode_e: inference/training mode carried with each accepted word.
//   - saturate(): signed clip from one width to a narrower one. The accumulator
//     blocks use it as well.
// -----------------------------------------------------------------------------
package neuron_stage_pkg;

  localparam string HIDDEN_YES = "yes";
  localparam string HIDDEN_NO  = "no";

  typedef enum logic {
    MODE_INFER = 1'b0,
    MODE_TRAIN = 1'b1
  } mode_e;

  // Widest signed quantity saturate() can handle. Any accumulator fed
  // through it must be no wider than this.
  localparam int unsigned SAT_W = 32;
  typedef logic signed [SAT_W-1:0] satWord_t;

  function automatic int unsigned accumWidth(input int unsigned np,
                                             input int unsigned wf);
    return $clog2(np) + wf;
  endfunction

  function automatic int unsigned stateWidth(input bit          hidden,
                                             input int unsigned wa,
                                             input int unsigned wf);
    return hidden ? wa : wf;
  endfunction

  // Clip a sign-extended value that originally had fromW significant bits
  // into the signed range of toW bits. The result is still sign-extended to
  // SAT_W bits, so callers take the low toW bits. Widening is a no-op.
  function automatic satWord_t saturate(input satWord_t    x,
                                        input int unsigned fromW,
                                        input int unsigned toW);
    satWord_t hi;
    satWord_t lo;
    if (toW >= fromW || toW == 0) begin
      return x;
    end
    hi = (satWord_t'(1) <<< (toW - 1)) - satWord_t'(1);
    lo = -(satWord_t'(1) <<< (toW - 1));
    if (x > hi) begin
      return hi;
    end
    if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/neuron_stage_act.sv
// -----------------------------------------------------------------------------
// neuron_act
//   Combinational activation and saturation for a single channel.
//   Hidden layer : act = ReLU (LEAK == 0) or leaky ReLU (arithmetic shift
//                  right by LEAK for negative sums); pre = sum unchanged.
//   Output layer : act = pre = sum clipped to the signed WF-bit range.
//
//   Parameters
//     HIDDEN  "yes" for a hidden layer, anything else for the output layer
//     WA      accumulator width of the incoming sum
//     WF      fixed-point word width (output-layer clip width)
//     LEAK    leaky-ReLU shift, 0 for plain ReLU
//   Ports
//     sum  in   WA  signed accumulator sum
//     act  out  WN  activated value
//     pre  out  WN  pre-activation value, saturated to WN bits
// -----------------------------------------------------------------------------
module neuron_act
  import neuron_stage_pkg::*;
#(
  parameter string        HIDDEN = HIDDEN_YES,
  parameter int unsigned  WA     = 6,
  parameter int unsigned  WF     = 4,
  parameter int unsigned  LEAK   = 0,
  localparam int unsigned WN     = stateWidth(HIDDEN == HIDDEN_YES, WA, WF)
) (
  input  logic [WA-1:0] sum,
  output logic [WN-1:0] act,
  output logic [WN-1:0] pre
);

  if (HIDDEN == HIDDEN_YES) begin : gHidden
    // Hidden layers keep the full accumulator width, so no clipping is needed.
    if (LEAK == 0) begin : gRelu
      always_comb begin
        act = sum[WA-1] ? '0 : sum;
      end
    end else begin : gLeaky
      // The arithmetic shift floors toward -inf, e.g. -5 >>> 1 = -3.
      always_comb begin
        act = sum[WA-1] ? WN'($signed(sum) >>> LEAK) : sum;
      end
    end

    always_comb begin
      pre = sum;
    end
  end else begin : gOutput
    // The linear output layer narrows to WF bits, so act and pre carry the
    // same clipped value.
    always_comb begin
      act = WN'(saturate(satWord_t'($signed(sum)), WA, WF));
      pre = WN'(saturate(satWord_t'($signed(sum)), WA, WF));
    end
  end

endmodule

// File: rtl/neuron_stage.sv
// -----------------------------------------------------------------------------
// neuron_stage
//   Activation stage for one network layer. Each accepted accumulator word
//   (NC signed sums) is activated per channel and forked to two independently
//   handshaked outputs:
//     State0 - activated values, loaded on every accepted word
//     State1 - pre-activation values, loaded only when iMode = 1 (training)
//
//   Parameters
//     HIDDEN  "yes" hidden layer (rectifier), "no" output layer (linear, clip)
//     NP      inputs summed per accumulator (sets growth bits)
//     NC      channels processed in parallel
//     WF      fixed-point word width
//     LEAK    leaky-ReLU shift for negative hidden sums, 0 = plain ReLU
//     WA      (derived) accumulator width per channel
//     WN      (derived) state width per channel
//
//   Ports
//     iCLK / iRST        clock, asynchronous active-high reset
//     iMode              0 = inference, 1 = training, taken with each word
//     iValid_AS_Accum0   input word valid
//     oReady_AS_Accum0   input word accepted when valid and ready are both high
//     iData_AS_Accum0    NC x WA sums, channel k at [k*WA +: WA]
//     oValid_BM_State0   activated state valid
//     iReady_BM_State0   State0 consumer ready
//     oData_BM_State0    NC x WN activated values
//     oValid_BM_State1   pre-activation state valid
//     iReady_BM_State1   State1 consumer ready
//     oData_BM_State1    NC x WN pre-activation values
// -----------------------------------------------------------------------------
module neuron_stage
  import neuron_stage_pkg::*;
#(
  parameter string        HIDDEN = HIDDEN_YES,
  parameter int unsigned  NP     = 4,
  parameter int unsigned  NC     = 4,
  parameter int unsigned  WF     = 4,
  parameter int unsigned  LEAK   = 0,
  localparam int unsigned WA     = accumWidth(NP, WF),
  localparam int unsigned WN     = stateWidth(HIDDEN == HIDDEN_YES, WA, WF)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iMode,
  input  logic             iValid_AS_Accum0,
  output logic             oReady_AS_Accum0,
  input  logic [NC*WA-1:0] iData_AS_Accum0,
  output logic             oValid_BM_State0,
  input  logic             iReady_BM_State0,
  output logic [NC*WN-1:0] oData_BM_State0,
  output logic             oValid_BM_State1,
  input  logic             iReady_BM_State1,
  output logic [NC*WN-1:0] oData_BM_State1
);

  logic [NC*WN-1:0] actWord;
  logic [NC*WN-1:0] preWord;
  mode_e            mode;
  logic             free0;
  logic             free1;
  logic             accept;
  logic             loadPre;

  // ---------------------------------------------------------------------------
  // Per-channel activation
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NC; k++) begin : gChan
    neuron_act #(
      .HIDDEN (HIDDEN),
      .WA     (WA),
      .WF     (WF),
      .LEAK   (LEAK)
    ) uAct (
      .sum (iData_AS_Accum0[k*WA +: WA]),
      .act (actWord[k*WN +: WN]),
      .pre (preWord[k*WN +: WN])
    );
  end

  // ---------------------------------------------------------------------------
  // Fork handshake
  // ---------------------------------------------------------------------------
  // Ready depends only on the registered valids and the downstream readies,
  // never on iValid. A word is taken only when both branches can hold it,
  // even if this word will not load State1. This keeps a pending training
  // word from being overtaken.
  always_comb begin
    free0   = !oValid_BM_State0 || iReady_BM_State0;
    free1   = !oValid_BM_State1 || iReady_BM_State1;
    mode    = mode_e'(iMode);
    accept  = iValid_AS_Accum0 && free0 && free1;
    loadPre = accept && (mode == MODE_TRAIN);
  end

  assign oReady_AS_Accum0 = free0 && free1;

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  // A load wins over a drain in the same cycle, so valid stays high with the
  // new data. Without a load, a valid falls only on its own handshake. The
  // data registers load only on acceptance, which holds them stable under
  // backpressure.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oValid_BM_State0 <= 1'b0;
      oValid_BM_State1 <= 1'b0;
      oData_BM_State0  <= '0;
      oData_BM_State1  <= '0;
    end else begin
      if (accept) begin
        oValid_BM_State0 <= 1'b1;
        oData_BM_State0  <= actWord;
      end else if (oValid_BM_State0 && iReady_BM_State0) begin
        oValid_BM_State0 <= 1'b0;
      end

      if (loadPre) begin
        oValid_BM_State1 <= 1'b1;
        oData_BM_State1  <= preWord;
      end else if (oValid_BM_State1 && iReady_BM_State1) begin
        oValid_BM_State1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_stage.sv
// -----------------------------------------------------------------------------
// tb_neuron_stage
//   Three neuron_stage instances share one input stream and the two
//   downstream readies:
//     H0 - hidden layer, plain ReLU
//     H1 - hidden layer, leaky ReLU (LEAK = 1)
//     O  - output layer (linear, clipped to WF bits)
//   A queue-based reference holds the words accepted and not yet consumed on
//   each stream. Every negedge, all outputs are compared with it. Directed
//   literal checks fix the activation arithmetic.
// -----------------------------------------------------------------------------
module tb_neuron_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        iMode;
  logic        iValid;
  logic [23:0] iData;
  logic        r0;
  logic        r1;

  logic        rdyH0, rdyH1, rdyO;
  logic        v0H0, v1H0, v0H1, v1H1, v0O, v1O;
  logic [23:0] d0H0, d1H0, d0H1, d1H1;
  logic [15:0] d0O, d1O;

  int checks = 0;
  int errors = 0;

  logic [23:0] q0[$];
  logic [23:0] q1[$];

  string dutName[3] = '{"H0", "H1", "O"};

  always #5 clk = ~clk;

  neuron_stage #(.HIDDEN("yes"), .NP(4), .NC(4), .WF(4), .LEAK(0)) uH0 (
    .iCLK(clk), .iRST(rst), .iMode(iMode),
    .iValid_AS_Accum0(iValid), .oReady_AS_Accum0(rdyH0), .iData_AS_Accum0(iData),
    .oValid_BM_State0(v0H0), .iReady_BM_State0(r0), .oData_BM_State0(d0H0),
    .oValid_BM_State1(v1H0), .iReady_BM_State1(r1), .oData_BM_State1(d1H0));

  neuron_stage #(.HIDDEN("yes"), .NP(4), .NC(4), .WF(4), .LEAK(1)) uH1 (
    .iCLK(clk), .iRST(rst), .iMode(iMode),
    .iValid_AS_Accum0(iValid), .oReady_AS_Accum0(rdyH1), .iData_AS_Accum0(iData),
    .oValid_BM_State0(v0H1), .iReady_BM_State0(r0), .oData_BM_State0(d0H1),
    .oValid_BM_State1(v1H1), .iReady_BM_State1(r1), .oData_BM_State1(d1H1));

  neuron_stage #(.HIDDEN("no"), .NP(4), .NC(4), .WF(4), .LEAK(0)) uO (
    .iCLK(clk), .iRST(rst), .iMode(iMode),
    .iValid_AS_Accum0(iValid), .oReady_AS_Accum0(rdyO), .iData_AS_Accum0(iData),
    .oValid_BM_State0(v0O), .iReady_BM_State0(r0), .oData_BM_State0(d0O),
    .oValid_BM_State1(v1O), .iReady_BM_State1(r1), .oData_BM_State1(d1O));

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int chanOf(input logic [23:0] w, input int k);
    logic [5:0] b;
    int v;
    b = w[k*6 +: 6];
    v = int'(b);
    if (v > 31) v -= 64;
    return v;
  endfunction

  function automatic logic [23:0] packCh(input int c0, input int c1, input int c2,
                                         input int c3, input int w);
    int c[4];
    logic [23:0] res;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    res = '0;
    for (int k = 0; k < 4; k++) res |= 24'((c[k] & ((1 << w) - 1)) << (k * w));
    return res;
  endfunction

  function automatic int clip(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  // Activation rules in plain integer arithmetic. Leaky ReLU is floor(x/2).
  function automatic int actOf(input int d, input int x);
    case (d)
      0:       return (x < 0) ? 0 : x;
      1:       return (x < 0) ? -((1 - x) / 2) : x;
      default: return clip(x, -8, 7);
    endcase
  endfunction

  function automatic logic [23:0] expAct(input int d, input logic [23:0] w);
    return packCh(actOf(d, chanOf(w, 0)), actOf(d, chanOf(w, 1)),
                  actOf(d, chanOf(w, 2)), actOf(d, chanOf(w, 3)), (d == 2) ? 4 : 6);
  endfunction

  function automatic logic [23:0] expPre(input int d, input logic [23:0] w);
    if (d != 2) return w;
    return packCh(clip(chanOf(w, 0), -8, 7), clip(chanOf(w, 1), -8, 7),
                  clip(chanOf(w, 2), -8, 7), clip(chanOf(w, 3), -8, 7), 4);
  endfunction

  // which: 0 ready, 1 valid0, 2 valid1, 3 data0, 4 data1
  function automatic logic [23:0] dutSig(input int d, input int which);
    logic [23:0] r;
    r = '0;
    case (d)
      0: case (which)
           0: r = 24'(rdyH0); 1: r = 24'(v0H0); 2: r = 24'(v1H0);
           3: r = d0H0;       4: r = d1H0;      default: r = '0;
         endcase
      1: case (which)
           0: r = 24'(rdyH1); 1: r = 24'(v0H1); 2: r = 24'(v1H1);
           3: r = d0H1;       4: r = d1H1;      default: r = '0;
         endcase
      default: case (which)
           0: r = 24'(rdyO);  1: r = 24'(v0O);  2: r = 24'(v1O);
           3: r = 24'(d0O);   4: r = 24'(d1O);  default: r = '0;
         endcase
    endcase
    return r;
  endfunction

  function automatic logic [23:0] randWord();
    int c[4];
    int sel;
    int extremes[4] = '{-32, 31, -1, 0};
    for (int k = 0; k < 4; k++) begin
      sel = int'($urandom_range(0, 7));
      if (sel < 4) c[k] = extremes[sel];
      else         c[k] = int'($urandom_range(0, 63)) - 32;
    end
    return packCh(c[0], c[1], c[2], c[3], 6);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [23:0] w, input logic m);
    tick();
    iValid = 1'b1;
    iData  = w;
    iMode  = m;
    tick();
    iValid = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s.%s.ready", tag, dutName[d]), dutSig(d, 0), 24'd1);
      check($sformatf("%s.%s.valid0", tag, dutName[d]), dutSig(d, 1), 24'd0);
      check($sformatf("%s.%s.valid1", tag, dutName[d]), dutSig(d, 2), 24'd0);
      check($sformatf("%s.%s.data0", tag, dutName[d]), dutSig(d, 3), 24'd0);
      check($sformatf("%s.%s.data1", tag, dutName[d]), dutSig(d, 4), 24'd0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one pending word per stream at most, held in a queue
  // ---------------------------------------------------------------------------
  always @(posedge clk or posedge rst) begin : modelProc
    logic rdy;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      rdy = (q0.size() == 0 || r0) && (q1.size() == 0 || r1);
      if (q0.size() != 0 && r0) void'(q0.pop_front());
      if (q1.size() != 0 && r1) void'(q1.pop_front());
      if (iValid && rdy) begin
        q0.push_back(iData);
        if (iMode) q1.push_back(iData);
      end
    end
  end

  always @(negedge clk) begin : compareProc
    logic expRdy;
    expRdy = (q0.size() == 0 || r0) && (q1.size() == 0 || r1);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s.ready", dutName[d]), dutSig(d, 0), 24'(expRdy));
      check($sformatf("%s.valid0", dutName[d]), dutSig(d, 1), 24'(q0.size() != 0));
      check($sformatf("%s.valid1", dutName[d]), dutSig(d, 2), 24'(q1.size() != 0));
      if (q0.size() != 0)
        check($sformatf("%s.data0", dutName[d]), dutSig(d, 3), expAct(d, q0[0]));
      if (q1.size() != 0)
        check($sformatf("%s.data1", dutName[d]), dutSig(d, 4), expPre(d, q1[0]));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimProc
    int sent;
    int cyc;
    logic acc;

    rst = 1'b1; iValid = 1'b0; iMode = 1'b0; iData = '0; r0 = 1'b1; r1 = 1'b1;
    #3;
    checkIdle("inReset");
    tick(); tick();
    rst = 1'b0;
    #1;
    checkIdle("afterReset");

    // Directed activation cases
    send(packCh(-5, 0, 7, 31, 6), 1'b0);
    check("reluH0.data0", d0H0, packCh(0, 0, 7, 31, 6));
    check("reluH0.valid0", 24'(v0H0), 24'd1);
    check("reluH0.valid1", 24'(v1H0), 24'd0);

    send(packCh(-5, -32, 3, -1, 6), 1'b0);
    check("leakyH1.data0", d0H1, packCh(-3, -16, 3, -1, 6));

    send(packCh(20, -20, 5, -8, 6), 1'b1);
    check("outO.data0", 24'(d0O), packCh(7, -8, 5, -8, 4));
    check("outO.data1", 24'(d1O), packCh(7, -8, 5, -8, 4));
    check("outO.valid0", 24'(v0O), 24'd1);
    check("outO.valid1", 24'(v1O), 24'd1);

    // Backpressure on State1 with State0 ready
    tick();
    r0 = 1'b1; r1 = 1'b0; iMode = 1'b1; iValid = 1'b1; iData = randWord();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bpReady", 24'(rdyH0), 24'd0);
      iData = randWord();
      iMode = 1'(($urandom_range(0, 1)));
    end
    r1 = 1'b1;

    // 16-word random sequence under random backpressure
    sent = 0; cyc = 0;
    iValid = 1'b1; iData = randWord(); iMode = 1'(($urandom_range(0, 1)));
    while (sent < 16 && cyc < 400) begin
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      #1;
      acc = iValid && rdyH0;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        iData  = randWord();
        iMode  = 1'(($urandom_range(0, 1)));
        iValid = ($urandom_range(0, 3) != 0);
      end else if (!iValid) begin
        iValid = 1'b1;
      end
    end
    check("bpSeqCount", 24'(sent), 24'd16);

    // Streaming with both readies high
    r0 = 1'b1; r1 = 1'b1; iValid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      iData = randWord();
      iMode = 1'(($urandom_range(0, 1)));
      tick();
      check("streamReady", 24'(rdyH0), 24'd1);
    end

    // Fully random traffic
    for (int i = 0; i < 300; i++) begin
      iValid = ($urandom_range(0, 3) != 0);
      iData  = randWord();
      iMode  = 1'(($urandom_range(0, 1)));
      r0     = ($urandom_range(0, 3) != 0);
      r1     = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain, then reset in the middle of a training burst
    iValid = 1'b0; r0 = 1'b1; r1 = 1'b1;
    tick(); tick(); tick();
    iMode = 1'b1; iValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iData = randWord();
      tick();
    end
    check("preReset.valid0", 24'(v0H0), 24'd1);
    check("preReset.valid1", 24'(v1H0), 24'd1);
    rst = 1'b1; iValid = 1'b0;
    #1;
    checkIdle("midReset");
    tick(); tick();
    rst = 1'b0;
    tick();
    send(packCh(9, -9, 1, -32, 6), 1'b1);
    check("postReset.H0.data0", d0H0, packCh(9, 0, 1, 0, 6));
    check("postReset.O.data1", 24'(d1O), packCh(7, -8, 1, -8, 4));
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_stage.md
# neuron_stage

Parametrised activation stage for one network layer. It takes NC signed accumulator sums per transfer from the accumulator stream and applies a per-layer activation: ReLU or leaky-ReLU for hidden layers, saturating linear for the output layer. It then forks the result to two independently handshaked state streams. State0 carries the activated value for forward propagation. State1 carries the pre-activation value, which the training path needs for back-propagation; State1 is driven only in training mode.

## Interface
- HIDDEN, "yes": "yes" selects a hidden layer (rectifier, full width); "no" selects an output layer (linear, saturated to WF bits).
- NP, 4: number of inputs summed per accumulator; sets the accumulator growth bits.
- NC, 4: number of neurons (channels) processed in parallel.
- WF, 4: fixed-point word width of weights and activations.
- LEAK, 0: leaky-ReLU right-shift for negative hidden inputs; 0 means plain ReLU (negative values give 0).
- WA (localparam): $clog2(NP)+WF, the accumulator width per channel.
- WN (localparam): WA if HIDDEN=="yes", else WF; the state width per channel.

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iMode  in  1  0 = inference, 1 = training; sampled with each accepted input word.
- iValid_AS_Accum0  in  1  input word valid.
- oReady_AS_Accum0  out  1  input word accepted when this and valid are both high.
- iData_AS_Accum0  in  NC*WA  NC signed two's-complement sums; channel k is at bits [k*WA +: WA].
- oValid_BM_State0  out  1  activated state valid.
- iReady_BM_State0  in  1  State0 consumer ready.
- oData_BM_State0  out  NC*WN  activated values, same channel packing as the input.
- oValid_BM_State1  out  1  pre-activation state valid (training only).
- iReady_BM_State1  in  1  State1 consumer ready.
- oData_BM_State1  out  NC*WN  pre-activation values, saturated to WN bits.

## Operation
- Per channel x (WA bits, signed):
  - Hidden, LEAK=0: a = (x<0) ? 0 : x.
  - Hidden, LEAK>0: a = (x<0) ? x>>>LEAK : x. The shift is arithmetic, so the result rounds toward −inf.
  - Output layer: a = x clipped to [−2^(WF−1), 2^(WF−1)−1].
- State1 payload p = x clipped to WN bits. For a hidden layer this is x unchanged.
- Fork: each output has its own valid flag and data register.
  - free0 = !oValid_BM_State0 | iReady_BM_State0.
  - free1 = !oValid_BM_State1 | iReady_BM_State1.
  - oReady_AS_Accum0 = free0 & free1. This is combinational from the output readies and the registered valids only, never from iValid.
- On acceptance:
  - State0 register loads a and oValid_BM_State0 sets.
  - If iMode=1, the State1 register loads p and oValid_BM_State1 sets.
  - If iMode=0, State1 is not loaded this transfer.
- A valid clears only on its own handshake (valid & ready) when no new load happens in the same cycle. Load and drain in the same cycle keeps valid high with the new data.
- Data on each output is held stable while its valid is high and ready is low.
- An iMode change with State1 still pending does not flush it: the pending State1 word drains normally. While State1 is pending with no ready, inputs stall even in inference mode.

## Timing
- Reset: both valids = 0; both data registers = 0. oReady_AS_Accum0 reads 1 during and after reset.
- Latency: acceptance in cycle n gives valid high in cycle n+1.
- Throughput: one word per cycle when the downstream readies are held high.
- A reset asserted mid-transfer drops all pending words. No output valid appears until a new input word is accepted after reset deasserts.
- Simultaneous: both outputs may handshake in the same cycle; each is independent.
- No combinational path from iData_AS_Accum0 to any output.

## Structure
- Shared network package holds:
  - the width function clog2(NP)+WF;
  - the HIDDEN string constants;
  - a saturate(x, from_width, to_width) function, also reused by the accumulator blocks.
- One sub-module, `neuron_act`: a combinational single-channel activation and saturation unit, instantiated NC times in a generate loop. The fork registers and handshake logic live in `neuron_stage`.

## Test plan
- Hidden, NP=4, WF=4 (WA=6), LEAK=0, iMode=0: channel inputs {−5, 0, 7, 31} → State0 {0, 0, 7, 31}; oValid_BM_State1 stays 0.
- Hidden, LEAK=1: inputs {−5, −32, 3, −1} → State0 {−3, −16, 3, −1}. The arithmetic shift rounds toward −inf, so −5 gives −3 and −1 gives −1.
- Output layer (HIDDEN="no", WF=4), iMode=1: inputs {20, −20, 5, −8} → State0 and State1 both {7, −8, 5, −8}; both valids rise one cycle after acceptance.
- Backpressure, iMode=1: hold iReady_BM_State1=0 for 5 cycles with State0 ready. oReady_AS_Accum0 must be 0 from the cycle after the first acceptance; the State1 data stays stable; no input word is lost or duplicated over a 16-word random sequence checked against a scoreboard.
- Streaming: both readies high with a continuous input → one output per cycle, latency exactly 1.
- Reset: assert iRST mid-burst with both valids high. Both valids drop to 0 asynchronously, before the next edge; after release, the first output matches the first word accepted after reset.
